// File: rtl/ultrasonic_ranger_pkg.sv
// Shared constants and FSM encoding for the ultrasonic ranger and its servo consumer.
package ultrasonic_ranger_pkg;

  localparam int unsigned OSC_HZ             = 50_000_000;
  localparam int unsigned SERVO_FRAME_CYCLES = 1_000_000;
  localparam int unsigned OBSTACLE_THRESHOLD = 350_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } ranger_state_e;

endpackage

// File: rtl/ultrasonic_ranger_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-cycle rise/fall pulses
// taken from the synchronized level against its one-cycle-delayed copy.
module sync_edge (
  input  logic osc,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge osc) begin
    if (!reset) begin
      meta    <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      meta    <= raw;
      level   <= meta;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranger: periodic trigger pulse, echo width measurement in osc cycles,
// saturating to MAX_ECHO ("far") on a missing or overlong echo.
module ultrasonic_ranger
  import ultrasonic_ranger_pkg::*;
#(
  parameter int unsigned PERIOD       = 3_000_000,
  parameter int unsigned TRIG_CYCLES  = 500,
  parameter int unsigned RISE_TIMEOUT = 1_500_000,
  parameter int unsigned MAX_ECHO     = 1_900_000
) (
  input  logic        osc,
  input  logic        reset,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_cnt,
  output logic        echo_valid,
  output logic        timeout
);

  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD - 1);
  localparam logic [31:0] TRIG_LAST   = 32'(TRIG_CYCLES);
  localparam logic [31:0] RISE_LAST   = 32'(RISE_TIMEOUT - 1);
  localparam logic [31:0] ECHO_MAX    = 32'(MAX_ECHO);

  ranger_state_e state, state_next;
  logic [31:0]   period_cnt;
  logic [31:0]   width, width_next;
  logic [31:0]   echo_cnt_next;
  logic          trig_next, valid_next, timeout_next;
  logic          echo_s, echo_rise, echo_fall;

  sync_edge u_echo_sync (
    .osc   (osc),
    .reset (reset),
    .raw   (echo),
    .level (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  always_ff @(posedge osc) begin
    if (!reset) begin
      state      <= IDLE;
      period_cnt <= '0;
      width      <= '0;
      trig       <= 1'b0;
      echo_cnt   <= ECHO_MAX;
      echo_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 32'd1;
      width      <= width_next;
      trig       <= trig_next;
      echo_cnt   <= echo_cnt_next;
      echo_valid <= valid_next;
      timeout    <= timeout_next;
    end
  end

  // One counter serves as trigger timer, rise timeout and echo width; only one is live per state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_next    = state;
    width_next    = width;
    trig_next     = trig;
    echo_cnt_next = echo_cnt;
    valid_next    = 1'b0;
    timeout_next  = timeout;
    case (state)
      IDLE: begin
        // A wrap seen outside IDLE is simply missed, so an overrun skips one trigger.
        if (period_cnt == '0) begin
          state_next = TRIG;
          trig_next  = 1'b1;
          width_next = 32'd1;
        end
      end
      TRIG: begin
        if (width == TRIG_LAST) begin
          trig_next  = 1'b0;
          state_next = WAIT_RISE;
          width_next = '0;
        end else begin
          width_next = width + 32'd1;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
          width_next = 32'd1;
        end else if (width == RISE_LAST) begin
          echo_cnt_next = ECHO_MAX;
          timeout_next  = 1'b1;
          valid_next    = 1'b1;
          state_next    = IDLE;
        end else begin
          width_next = width + 32'd1;
        end
      end
      MEASURE: begin
        // Fall is tested first so a fall coinciding with saturation reports a real width.
        if (echo_fall) begin
          echo_cnt_next = width;
          timeout_next  = 1'b0;
          valid_next    = 1'b1;
          state_next    = IDLE;
        end else if (width == ECHO_MAX) begin
          echo_cnt_next = ECHO_MAX;
          timeout_next  = 1'b1;
          valid_next    = 1'b1;
          state_next    = IDLE;
        end else if (echo_s) begin
          width_next = width + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with scaled-down timing parameters.
module tb_ultrasonic_ranger;

  localparam int P = 200;
  localparam int T = 5;
  localparam int R = 100;
  localparam int M = 150;

  logic        osc;
  logic        reset;
  logic        echo;
  logic        trig;
  logic [31:0] echo_cnt;
  logic        echo_valid;
  logic        timeout;

  int          nvec, nerr, cyc, vcount, unstable;
  int          last_rise_cyc, last_rise_v, n;
  logic [31:0] last_cnt;

  ultrasonic_ranger #(
    .PERIOD       (P),
    .TRIG_CYCLES  (T),
    .RISE_TIMEOUT (R),
    .MAX_ECHO     (M)
  ) dut (
    .osc        (osc),
    .reset      (reset),
    .echo       (echo),
    .trig       (trig),
    .echo_cnt   (echo_cnt),
    .echo_valid (echo_valid),
    .timeout    (timeout)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; lands on the falling edge. Tracks strobes and any echo_cnt change without one.
  task automatic step();
    logic rst_seen;
    rst_seen = reset;
    @(posedge osc);
    @(negedge osc);
    cyc++;
    if (rst_seen) begin
      if (echo_valid) vcount++;
      else if (echo_cnt !== last_cnt) unstable++;
    end
    last_cnt = echo_cnt;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_trig(input int exp_gap, input int exp_pulses);
    int w;
    int h;
    w = 0;
    h = 0;
    while (!trig && w < 3 * P) begin
      step();
      w++;
    end
    check("trig_rise", trig, 1);
    check("trig_gap", cyc - last_rise_cyc, exp_gap);
    check("valid_per_period", vcount - last_rise_v, exp_pulses);
    last_rise_cyc = cyc;
    last_rise_v   = vcount;
    while (trig && h < 4 * T) begin
      h++;
      step();
    end
    check("trig_width", h, T);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!echo_valid && k < 2 * P) begin
      step();
      k++;
    end
    check("valid_seen", echo_valid, 1);
  endtask

  task automatic pulse_echo(input int delay, input int width);
    steps(delay);
    echo = 1'b1;
    steps(width);
    echo = 1'b0;
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; vcount = 0; unstable = 0;
    last_cnt = '0;
    reset = 1'b0;
    echo  = 1'b0;
    steps(3);
    check("rst_trig", trig, 0);
    check("rst_echo_cnt", echo_cnt, M);
    check("rst_valid", echo_valid, 0);
    check("rst_timeout", timeout, 0);

    // No echo: trigger right after release, timeout R cycles after trig falls.
    last_rise_cyc = cyc;
    last_rise_v   = vcount;
    reset = 1'b1;
    wait_trig(1, 0);
    wait_valid(n);
    check("noecho_delay", n, R);
    check("noecho_cnt", echo_cnt, M);
    check("noecho_timeout", timeout, 1);
    step();
    check("noecho_single_strobe", echo_valid, 0);

    // Normal echo of 120 cycles.
    wait_trig(P, 1);
    pulse_echo(19, 120);
    wait_valid(n);
    check("w120_cnt", echo_cnt, 120);
    check("w120_timeout", timeout, 0);

    // Width exactly MAX_ECHO: fall coincides with saturation and wins.
    wait_trig(P, 1);
    pulse_echo(19, M);
    wait_valid(n);
    check("wmax_cnt", echo_cnt, M);
    check("wmax_timeout", timeout, 0);

    // Overlong echo saturates; late fall gives no strobe; echo then sticks high.
    wait_trig(P, 1);
    steps(19);
    echo = 1'b1;
    wait_valid(n);
    check("long_delay", n, M + 3);
    check("long_cnt", echo_cnt, M);
    check("long_timeout", timeout, 1);
    steps(160 - n);
    echo = 1'b0;
    steps(5);
    echo = 1'b1;

    // Echo already high at trigger: no rise edge, so rise timeout.
    wait_trig(P, 1);
    wait_valid(n);
    check("stuck_delay", n, R);
    check("stuck_cnt", echo_cnt, M);
    check("stuck_timeout", timeout, 1);
    echo = 1'b0;

    // Back-to-back 130 then 90.
    wait_trig(P, 1);
    pulse_echo(19, 130);
    wait_valid(n);
    check("b2b_first_cnt", echo_cnt, 130);
    check("b2b_first_timeout", timeout, 0);
    wait_trig(P, 1);
    pulse_echo(19, 90);
    wait_valid(n);
    check("b2b_second_cnt", echo_cnt, 90);

    // Reset in the middle of a measurement.
    wait_trig(P, 1);
    steps(19);
    echo = 1'b1;
    steps(61);
    reset = 1'b0;
    step();
    check("midrst_trig", trig, 0);
    check("midrst_cnt", echo_cnt, M);
    check("midrst_valid", echo_valid, 0);
    check("midrst_timeout", timeout, 0);
    echo = 1'b0;
    last_rise_cyc = cyc;
    last_rise_v   = vcount;
    reset = 1'b1;
    wait_trig(1, 0);
    pulse_echo(19, 50);
    wait_valid(n);
    check("resume_cnt", echo_cnt, 50);
    check("resume_timeout", timeout, 0);

    // Measurement spanning the period wrap: that trigger is skipped.
    wait_trig(P, 1);
    pulse_echo(89, 140);
    wait_valid(n);
    check("overrun_cnt", echo_cnt, 140);
    check("overrun_timeout", timeout, 0);
    wait_trig(2 * P, 1);

    check("cnt_stable_between_strobes", unstable, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Upstream stage of servomotor. Drives the HC-SR04-style ultrasonic sensor: fires a periodic trigger pulse, then measures the echo pulse width in osc cycles.
- Publishes the width as echo_cnt, which servomotor consumes directly. Its obstacle threshold is echo_cnt < 350000 (7 ms, ~120 cm at 50 MHz).
- Holds the last result between measurements and saturates to "far" on a missing or overlong echo.

Parameters:
- PERIOD, 3000000, measurement cycle length in osc cycles (60 ms at 50 MHz).
- TRIG_CYCLES, 500, trigger high time (10 us).
- RISE_TIMEOUT, 1500000, max cycles from trigger fall to echo rise.
- MAX_ECHO, 1900000, echo width saturation value (38 ms, sensor no-object pulse).

Ports:
- osc  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- echo  in  1  raw sensor echo, asynchronous to osc.
- trig  out  1  sensor trigger.
- echo_cnt  out  32  last measured echo width in osc cycles, feeds servomotor.
- echo_valid  out  1  one-cycle strobe when echo_cnt updates.
- timeout  out  1  level: last measurement saturated (no rise, or width reached MAX_ECHO).

Behaviour:
- All registers update on posedge osc. Reset is sampled only on osc edges, with reset==0 meaning reset.
- Reset values: trig=0, echo_cnt=MAX_ECHO (far, so servo stays in default state at boot), echo_valid=0, timeout=0, period counter=0, FSM=IDLE.
- echo passes through a 2-flop synchronizer (echo_s). Rise and fall are detected on echo_s against its 1-cycle-delayed copy. Total input latency is 2–3 cycles.
- Period counter free-runs 0..PERIOD-1 and wraps to 0 regardless of FSM state.
- FSM states:
  - IDLE: when period counter==0, go to TRIG and set trig=1.
  - TRIG: trig held high for exactly TRIG_CYCLES cycles, then trig=0 and go to WAIT_RISE with the width counter cleared.
  - WAIT_RISE:
    - On an echo_s rise edge, go to MEASURE with width=1.
    - If RISE_TIMEOUT cycles elapse with no rise, set echo_cnt=MAX_ECHO, timeout=1, pulse echo_valid, and go to IDLE.
    - An echo already high on entry does not count; only a rise edge starts a measurement.
  - MEASURE:
    - Width increments each cycle echo_s is high.
    - On the fall edge, set echo_cnt=width, timeout=0, pulse echo_valid, and go to IDLE.
    - If width reaches MAX_ECHO, set echo_cnt=MAX_ECHO, timeout=1, pulse echo_valid, and go to IDLE.
- Simultaneous fall edge and width==MAX_ECHO: the fall wins and the result is echo_cnt=MAX_ECHO with timeout=0.
- Overrun: if the period counter hits 0 while the FSM is not in IDLE, that trigger is skipped (no retrigger mid-measurement). The next trigger occurs at the following wrap.
- echo_cnt changes only on echo_valid cycles, so the downstream block sees a stable value between strobes.
- Width counter is 32 bits, bounded by MAX_ECHO, and never wraps.
- Reset asserted mid-operation: on the next osc edge trig=0, the FSM returns to IDLE, and echo_cnt returns to MAX_ECHO.

Decomposition:
- Shared package holds:
  - OSC_HZ=50000000.
  - The 20 ms servo frame constant 1000000.
  - The obstacle threshold 350000.
  - The FSM state encoding (IDLE=0, TRIG=1, WAIT_RISE=2, MEASURE=3).
- One natural sub-module, sync_edge: 2-flop synchronizer plus rise/fall pulse outputs. It is reusable for other async sensor inputs.
- The FSM and counters stay in ultrasonic_ranger.

Test Plan:
- Reset release, no echo: trig high for exactly 500 cycles starting at period count 0. After 1500000 more cycles, echo_valid pulses once with echo_cnt=1900000 and timeout=1.
- Echo rises 20000 cycles after trig falls, held 200000 cycles: one echo_valid strobe, echo_cnt=200000 (±0 after accounting for the 2-cycle sync), timeout=0. Servo-side check: 200000<350000 means obstacle.
- Echo held 2000000 cycles: at width 1900000, echo_cnt=1900000 and timeout=1. The late fall produces no further strobe, and the next trigger fires at the following period wrap.
- Echo stuck high before trigger: no measurement starts; after RISE_TIMEOUT, echo_cnt=1900000 and timeout=1.
- Reset pulled low during MEASURE (width 100000): on the next edge trig=0, the FSM is IDLE and echo_cnt=1900000. The measurement resumes normally after reset release.
- Back-to-back widths 400000 then 300000: echo_cnt goes 400000→300000 with exactly one echo_valid per period. The value stays stable between strobes.
